c3_src_loader: RTL and testbench
================================

C3_SRC_LOADER -- requirements
Module: c3_src_loader

Interface
REQ-001 Parameter MAP_WORDS, default 196, SHALL set words per feature map (14x14); legal range 1..256.
REQ-002 Parameter NUM_MAPS, default 6, SHALL set feature maps per frame; legal range 1..256.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse requesting a frame load.
REQ-006 in_data  input  16  SHALL carry the source pixel word.
REQ-007 in_valid  input  1  SHALL qualify in_data.
REQ-008 in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-009 wr_data  output  16  SHALL drive source-buffer write data.
REQ-010 wr_addr  output  32  SHALL drive the buffer write address: [31:16]=0, [15:8]=map index, [7:0]=word index.
REQ-011 we  output  1  SHALL drive the source-buffer write enable.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 done  output  1  SHALL pulse one cycle when the whole frame has been written.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-015 IDLE: in_ready=0; start=1 -> LOAD next cycle with word_cnt=0, map_cnt=0.
REQ-016 LOAD: in_ready=1 combinationally from state only, never from in_valid.
REQ-017 Accept = in_valid & in_ready; in_valid while in_ready=0 SHALL be ignored, no write.
REQ-018 Accept in cycle N SHALL give we=1 in cycle N+1 with wr_data=in_data(N), wr_addr={16'h0, map_cnt(N), word_cnt(N)}; outputs registered, latency 1.
REQ-019 Cycles without accept SHALL have we=0; wr_data/wr_addr hold their last value.
REQ-020 Per accept: word_cnt increments; at MAP_WORDS-1 it wraps to 0 and map_cnt increments.
REQ-021 Accept of word MAP_WORDS-1 of map NUM_MAPS-1 SHALL move LOAD -> DRAIN; counters reset to 0.
REQ-022 DRAIN: in_ready=0, last write issued (we=1); -> DONE next cycle.
REQ-023 DONE: done=1, we=0, in_ready=0, busy=1; -> IDLE next cycle.
REQ-024 start while not in IDLE SHALL be ignored, no counter effect.
REQ-025 Stalls (in_valid=0) in LOAD of any length SHALL not alter counters or outputs except we=0.
REQ-026 Total writes per frame SHALL equal MAP_WORDS*NUM_MAPS, each address written exactly once, in ascending word then map order.
REQ-027 wr_addr[7:0] SHALL never exceed MAP_WORDS-1; wr_addr[15:8] never exceed NUM_MAPS-1.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, word_cnt=0, map_cnt=0, we=0, done=0, busy=0, in_ready=0, wr_data=0, wr_addr=0.
REQ-029 Reset mid-frame SHALL abandon the frame; no further writes until a new start after rst_n=1; partially written buffer contents are not cleared.
REQ-030 First start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-031 Default params, start, in_valid held 1, data=0..1175 -> 1176 writes, write k at wr_addr=32'h0000_{k/196,k%196}, e.g. k=196 -> 32'h0000_0100, data 196; done pulses 2 cycles after last accept.
REQ-032 Boundary: accept #195 -> wr_addr 32'h0000_00C3, #196 -> 32'h0000_0100; last write 32'h0000_05C3.
REQ-033 Random in_valid gaps (50%) -> identical address/data sequence to REQ-031, we=0 in gap cycles, no duplicates.
REQ-034 start pulsed during LOAD and DONE -> ignored; in_valid=1 in IDLE -> no we, in_ready=0.
REQ-035 rst_n=0 after 300 accepts -> all outputs 0 asynchronously; new start reloads from 32'h0000_0000.
REQ-036 MAP_WORDS=4, NUM_MAPS=2 -> 8 writes at 0x000..0x003, 0x100..0x103, then done.

Source files
------------

// File: rtl/c3_src_loader.sv
// Streams one frame of NUM_MAPS x MAP_WORDS source pixels into the C3 source buffer.
// Each accepted word is written one cycle later at {map index, word index}.
module c3_src_loader #(
  parameter int MAP_WORDS = 196,
  parameter int NUM_MAPS  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] wr_data,
  output logic [31:0] wr_addr,
  output logic        we,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] LAST_WORD = 8'(MAP_WORDS - 1);
  localparam logic [7:0] LAST_MAP  = 8'(NUM_MAPS - 1);

  logic [1:0] state;
  logic [7:0] word_cnt;
  logic [7:0] map_cnt;
  logic       accept;

  // Handshake depends on state only so upstream never sees a combinational loop.
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= 8'd0;
      map_cnt  <= 8'd0;
      we       <= 1'b0;
      wr_data  <= 16'd0;
      wr_addr  <= 32'd0;
    end else begin
      we <= accept;
      if (accept) begin
        wr_data <= in_data;
        wr_addr <= {16'h0000, map_cnt, word_cnt};
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            word_cnt <= 8'd0;
            map_cnt  <= 8'd0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= 8'd0;
              // Last word of the last map closes the frame.
              if (map_cnt == LAST_MAP) begin
                map_cnt <= 8'd0;
                state   <= DRAIN;
              end else begin
                map_cnt <= map_cnt + 8'd1;
              end
            end else begin
              word_cnt <= word_cnt + 8'd1;
            end
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c3_src_loader.sv
// Randomized self-checking bench for c3_src_loader against a frame-level reference model,
// plus a short directed run of a MAP_WORDS=4, NUM_MAPS=2 instance.
module tb_c3_src_loader;

  localparam int MW    = 196;
  localparam int NM    = 6;
  localparam int TOTAL = MW * NM;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] wr_data;
  logic [31:0] wr_addr;
  logic        we;
  logic        busy;
  logic        done;

  logic        s_start;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_wr_data;
  logic [31:0] s_wr_addr;
  logic        s_we;
  logic        s_busy;
  logic        s_done;

  c3_src_loader #(.MAP_WORDS(MW), .NUM_MAPS(NM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_data(wr_data), .wr_addr(wr_addr), .we(we), .busy(busy), .done(done)
  );

  c3_src_loader #(.MAP_WORDS(4), .NUM_MAPS(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .wr_data(s_wr_data), .wr_addr(s_wr_addr), .we(s_we), .busy(s_busy),
    .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is "loading" until TOTAL words are taken, then two tail cycles.
  bit          m_loading;
  int          m_after;
  int          m_k;
  logic        m_we;
  logic [31:0] m_addr;
  logic [15:0] m_data;

  int checks;
  int errors;
  int cyc;
  int last_acc_cyc;
  int done_cyc;
  int writes;
  logic [31:0] wr_log [0:TOTAL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_loading = 1'b0;
    m_after   = 0;
    m_k       = 0;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_data    = 16'd0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".we"},       {31'd0, we},       {31'd0, m_we});
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, m_loading});
    check({tag, ".busy"},     {31'd0, busy},     {31'd0, (m_loading || m_after == 1 || m_after == 2)});
    check({tag, ".done"},     {31'd0, done},     {31'd0, (m_after == 2)});
    check({tag, ".wr_addr"},  wr_addr,           m_addr);
    check({tag, ".wr_data"},  {16'd0, wr_data},  {16'd0, m_data});
    if (we === 1'b1) begin
      if (writes < TOTAL) wr_log[writes] = wr_addr;
      writes++;
    end
    if (done === 1'b1) done_cyc = cyc;
  endtask

  // Drives one cycle of inputs, advances the model across the edge, returns at the negedge.
  task automatic applyStimulus(input logic s, input logic v, input logic [15:0] d);
    bit was_idle;
    bit acc;
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      modelReset();
    end else begin
      was_idle = !m_loading && m_after == 0;
      acc      = m_loading && v;
      if (m_after != 0) m_after = (m_after == 2) ? 0 : m_after + 1;
      m_we = acc;
      if (acc) begin
        m_addr = 32'((m_k / MW) * 256 + (m_k % MW));
        m_data = d;
        m_k++;
        last_acc_cyc = cyc - 1;
        if (m_k == TOTAL) begin
          m_loading = 1'b0;
          m_after   = 1;
        end
      end
      if (was_idle && s) begin
        m_loading = 1'b1;
        m_k       = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int sw;
    int sdone;
    checks = 0; errors = 0; cyc = 0; writes = 0; last_acc_cyc = -100; done_cyc = -1;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'd0;
    s_start = 1'b0; s_valid = 1'b0; s_data = 16'd0;
    modelReset();

    $display("[TB] reset");
    applyStimulus(0, 0, 16'd0);
    applyStimulus(0, 1, 16'h1234);
    checkOutput("reset");
    rst_n = 1'b1;

    $display("[TB] frame 1: in_valid held high");
    applyStimulus(1, 0, 16'd0);
    checkOutput("start1");
    writes = 0;
    for (int i = 0; i < TOTAL + 50; i++) begin
      applyStimulus(0, 1, 16'(m_k));
      checkOutput("f1");
      if (!m_loading && m_after == 0) break;
    end
    check("f1_writes",   32'(writes), 32'(TOTAL));
    check("f1_addr195",  wr_log[195], 32'h0000_00C3);
    check("f1_addr196",  wr_log[196], 32'h0000_0100);
    check("f1_addrlast", wr_log[TOTAL-1], 32'h0000_05C3);
    check("f1_done_lat", 32'(done_cyc - last_acc_cyc), 32'd2);

    $display("[TB] in_valid while idle");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 16'hBEEF);
      checkOutput("idle_valid");
    end

    $display("[TB] frame 2: random gaps, stray starts");
    applyStimulus(1, 0, 16'd0);
    checkOutput("start2");
    writes = 0;
    for (int i = 0; i < 6 * TOTAL; i++) begin
      logic v;
      logic s;
      v = 1'($urandom_range(0, 1));
      s = (m_after == 2) || (m_loading && $urandom_range(0, 15) == 0);
      applyStimulus(s, v, v ? 16'(m_k) : 16'($urandom));
      checkOutput("f2");
      if (!m_loading && m_after == 0) break;
    end
    applyStimulus(0, 0, 16'd0);
    checkOutput("f2_after_done");
    check("f2_writes", 32'(writes), 32'(TOTAL));
    for (int i = 0; i < TOTAL; i++)
      check("f2_order", wr_log[i], 32'((i / MW) * 256 + (i % MW)));

    $display("[TB] frame 3: reset after 300 accepts");
    applyStimulus(1, 0, 16'd0);
    checkOutput("start3");
    for (int i = 0; i < 3000 && m_k < 300; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      applyStimulus(0, v, 16'($urandom));
      checkOutput("f3");
    end
    check("f3_reached300", 32'(m_k), 32'd300);
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 16'h5555);
    checkOutput("post_reset_idle");
    applyStimulus(1, 0, 16'd0);
    checkOutput("restart");
    applyStimulus(0, 1, 16'hA001);
    checkOutput("reload0");
    check("reload_addr0", wr_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 16'(16'hA002 + i));
      checkOutput("reload");
    end
    in_valid = 1'b0;

    $display("[TB] small instance 4x2");
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    check("s_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    sw = 0;
    sdone = 0;
    for (int i = 0; i < 12; i++) begin
      s_data = 16'(100 + i);
      @(posedge clk);
      @(negedge clk);
      if (s_we === 1'b1) begin
        check("s_addr", s_wr_addr, 32'((sw / 4) * 256 + (sw % 4)));
        check("s_data", {16'd0, s_wr_data}, 32'(100 + sw));
        sw++;
      end
      if (s_done === 1'b1) begin
        check("s_done_after_all", 32'(sw), 32'd8);
        sdone++;
      end
    end
    s_valid = 1'b0;
    check("s_writes", 32'(sw), 32'd8);
    check("s_done_count", 32'(sdone), 32'd1);
    check("s_idle", {31'd0, s_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
